// File: rtl/ysyx22041405_lsu_pkg.sv
// Shared memory-op codes, FSM state encoding and op-decode helpers for the LSU.
// Latency: none (definitions only).
// Backpressure: n/a.
package ysyx22041405_lsu_pkg;

  localparam logic [3:0] MOP_NONE = 4'd0;
  localparam logic [3:0] MOP_LB   = 4'd1;
  localparam logic [3:0] MOP_LH   = 4'd2;
  localparam logic [3:0] MOP_LW   = 4'd3;
  localparam logic [3:0] MOP_LBU  = 4'd4;
  localparam logic [3:0] MOP_LHU  = 4'd5;
  localparam logic [3:0] MOP_SB   = 4'd6;
  localparam logic [3:0] MOP_SH   = 4'd7;
  localparam logic [3:0] MOP_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  function automatic logic mop_is_load(input logic [3:0] op);
    return (op == MOP_LB) || (op == MOP_LH) || (op == MOP_LW) ||
           (op == MOP_LBU) || (op == MOP_LHU);
  endfunction

  function automatic logic mop_is_store(input logic [3:0] op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

  // Access wider than its natural alignment allows (bytes never misalign).
  function automatic logic mop_misaligned(input logic [3:0] op, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    case (op)
      MOP_LH, MOP_LHU, MOP_SH: mis = a[0];
      MOP_LW, MOP_SW:          mis = |a;
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx22041405_lsu_align.sv
// Byte-lane steering: strobes and replicated store data out, aligned/extended load data in.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module ysyx22041405_lsu_align
  import ysyx22041405_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [1:0]       a,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] rdata,
  output logic [3:0]       wstrb,
  output logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection; halves only look at a[1] so a stray a[0] cannot split a half across words
  always_comb begin
    byte_v    = rdata[{a, 3'b000} +: 8];
    half_v    = a[1] ? rdata[31:16] : rdata[15:0];
    wstrb     = 4'b0000;
    wdata     = rs2;
    load_data = rdata;
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: wstrb = 4'b0001 << a;
      MOP_LH, MOP_LHU, MOP_SH: wstrb = 4'b0011 << {a[1], 1'b0};
      MOP_LW, MOP_SW:          wstrb = 4'b1111;
      default:                 wstrb = 4'b0000;
    endcase
    case (op)
      MOP_SB:  wdata = {(WIDTH/8){rs2[7:0]}};
      MOP_SH:  wdata = {(WIDTH/16){rs2[15:0]}};
      default: wdata = rs2;
    endcase
    case (op)
      MOP_LB:  load_data = {{(WIDTH-8){byte_v[7]}}, byte_v};
      MOP_LBU: load_data = {{(WIDTH-8){1'b0}}, byte_v};
      MOP_LH:  load_data = {{(WIDTH-16){half_v[15]}}, half_v};
      MOP_LHU: load_data = {{(WIDTH-16){1'b0}}, half_v};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx22041405_lsu.sv
// Load/store unit: one instruction at a time, req/gnt + rvalid data bus, one result per instruction to WBU.
// Latency: non-mem 1 cycle; mem 1 + gnt wait + rvalid wait + 1 (min 3).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional YSYX22041405_LSU_MISALIGN_EN.
module ysyx22041405_lsu
  import ysyx22041405_lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_alu_result,
  input  logic [WIDTH-1:0] in_rs2_data,
  input  logic [3:0]       in_mem_op,
  input  logic             in_rf_we,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [WIDTH-1:0] in_pc,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_wstrb,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_wdata,
  output logic             out_rf_we,
  output logic [RD_W-1:0]  out_rd,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_misalign
);

  lsu_state_e state_q, state_d;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] rs2_q;
  logic             rf_we_q;
  logic [RD_W-1:0]  rd_q;
  logic [WIDTH-1:0] pc_q;

  logic [3:0]       al_wstrb;
  logic [WIDTH-1:0] al_wdata;
  logic [WIDTH-1:0] ld_data;

  logic accept;
  logic acc_misalign;
  logic go_mem;
  logic rsp_hit;

`ifdef YSYX22041405_LSU_MISALIGN_EN
  logic misalign_q;

  assign acc_misalign = mop_misaligned(in_mem_op, in_alu_result[1:0]);
  assign out_misalign = misalign_q;

  // Misalign flag rides with the instruction; only ever set on the IDLE->DONE shortcut
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        misalign_q <= 1'b0;
    else if (accept) misalign_q <= acc_misalign;
  end
`else
  assign acc_misalign = 1'b0;
  assign out_misalign = 1'b0;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign go_mem    = (mop_is_load(in_mem_op) | mop_is_store(in_mem_op)) & ~acc_misalign;
  // Responses only count in WAIT, so stale rvalids (e.g. after reset) are dropped
  assign rsp_hit   = (state_q == ST_WAIT) & dmem_rvalid;

  // Bus side is driven from latched state only, so it is stable for the whole REQ phase
  assign dmem_req   = (state_q == ST_REQ);
  assign dmem_we    = dmem_req & mop_is_store(op_q);
  assign dmem_addr  = dmem_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
  assign dmem_wdata = dmem_req ? al_wdata : '0;
  assign dmem_wstrb = dmem_req ? al_wstrb : 4'b0000;

  assign out_rd = rd_q;
  assign out_pc = pc_q;

  ysyx22041405_lsu_align #(.WIDTH(WIDTH)) u_align (
    .op        (op_q),
    .a         (addr_q[1:0]),
    .rs2       (rs2_q),
    .rdata     (dmem_rdata),
    .wstrb     (al_wstrb),
    .wdata     (al_wdata),
    .load_data (ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: a gnt cycle never consumes rvalid, the bus delivers it strictly later
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = go_mem ? ST_REQ : ST_DONE;
      ST_REQ:  if (dmem_gnt) state_d = ST_WAIT;
      ST_WAIT: if (dmem_rvalid) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the instruction on accept and capture the WBU result on entry to DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= MOP_NONE;
      addr_q    <= '0;
      rs2_q     <= '0;
      rf_we_q   <= 1'b0;
      rd_q      <= '0;
      pc_q      <= '0;
      out_wdata <= '0;
      out_rf_we <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= in_mem_op;
        addr_q  <= in_alu_result;
        rs2_q   <= in_rs2_data;
        rf_we_q <= in_rf_we;
        rd_q    <= in_rd;
        pc_q    <= in_pc;
      end
      if (accept && !go_mem) begin
        out_wdata <= in_alu_result;
        out_rf_we <= in_rf_we & ~acc_misalign;
      end else if (rsp_hit) begin
        out_wdata <= mop_is_load(op_q) ? ld_data : addr_q;
        out_rf_we <= mop_is_load(op_q) & rf_we_q;
      end
    end
  end

endmodule
